// File: rtl/cmd_assembler_pkg.sv
// Shared command layout and FSM encoding for the host command path.
// The field positions are also used by the downstream scheduler.
package cmd_assembler_pkg;

   localparam int WORD_W    = 16;
   localparam int NUM_WORDS = 5;
   localparam int CMD_W     = WORD_W * NUM_WORDS;
   localparam int IDX_W     = 3;

   localparam int TIME_H = 79;
   localparam int TIME_L = 48;
   localparam int DATA_H = 47;
   localparam int DATA_L = 16;
   localparam int ADDR_H = 15;
   localparam int ADDR_L = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_PUSH    = 2'd2
   } state_e;

   // Bit offset of bus word <idx> inside the assembled command.
   function automatic int word_lsb(input logic [IDX_W-1:0] idx);
      return int'(idx) * WORD_W;
   endfunction

endpackage

// File: rtl/cmd_assembler_if.sv
// Host word stream in, assembled-command FIFO write port out.
// slave = assembler side, master = host/FIFO side.
interface cmd_assembler_if;
   import cmd_assembler_pkg::*;

   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_sof;
   logic              in_ready;
   logic [CMD_W-1:0]  cmd_fifo_din;
   logic              cmd_fifo_wr_en;
   logic              cmd_fifo_full;

   modport slave (
      input  in_data, in_valid, in_sof, cmd_fifo_full,
      output in_ready, cmd_fifo_din, cmd_fifo_wr_en
   );

   modport master (
      output in_data, in_valid, in_sof, cmd_fifo_full,
      input  in_ready, cmd_fifo_din, cmd_fifo_wr_en
   );

endinterface

// File: rtl/cmd_assembler_idle_timer.sv
// Idle-cycle counter: load clears it, count advances it; expire flags the
// TIMEOUT_CYCLES-th consecutive counted cycle combinationally. No backpressure.
module idle_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic count,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expire = count && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (load || expire) begin
         cnt_d = '0;
      end else if (count) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cmd_assembler.sv
// Packs five 16-bit host words into one 80-bit command; write strobe 1 cycle after w4.
// Backpressure: in_ready drops while a command waits for FIFO space.
module cmd_assembler
   import cmd_assembler_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   cmd_assembler_if.slave   bus,
   input  logic             clear_err,
   output logic             err_resync,
   output logic             err_timeout,
   output logic [CNT_W-1:0] cmd_count
);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CMD_W-1:0]   din_q, din_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_resync_q, err_resync_d;
   logic               err_timeout_q, err_timeout_d;

   logic               in_rdy;
   logic               wr_en;
   logic               xfer;
   logic               expire;
   logic               set_resync;
   logic               set_timeout;

   assign xfer = bus.in_valid && in_rdy;

   // Any transfer, or being outside COLLECT, keeps the idle count at zero.
   idle_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (xfer || (state_q != ST_COLLECT)),
      .count  ((state_q == ST_COLLECT) && !xfer),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         din_q         <= '0;
         cnt_q         <= '0;
         err_resync_q  <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         din_q         <= din_d;
         cnt_q         <= cnt_d;
         err_resync_q  <= err_resync_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      din_d       = din_q;
      cnt_d       = cnt_q;
      set_resync  = 1'b0;
      set_timeout = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (xfer && bus.in_sof) begin
               din_d[ADDR_H:ADDR_L] = bus.in_data;
               idx_d                = IDX_W'(1);
               state_d              = ST_COLLECT;
            end else if (xfer) begin
               set_resync = 1'b1;
            end
         end
         ST_COLLECT: begin
            // A new sof always restarts framing, even on the expiry cycle.
            if (xfer && bus.in_sof) begin
               din_d[ADDR_H:ADDR_L] = bus.in_data;
               idx_d                = IDX_W'(1);
               set_resync           = 1'b1;
            end else if (xfer) begin
               din_d[word_lsb(idx_q) +: WORD_W] = bus.in_data;
               idx_d                            = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                  idx_d   = '0;
                  state_d = ST_PUSH;
               end
            end else if (expire) begin
               idx_d       = '0;
               state_d     = ST_IDLE;
               set_timeout = 1'b1;
            end
         end
         ST_PUSH: begin
            if (wr_en) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = ST_IDLE;
            end
         end
         default: begin
            idx_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      err_resync_d  = set_resync  || (err_resync_q  && !clear_err);
      err_timeout_d = set_timeout || (err_timeout_q && !clear_err);
   end

   always_comb begin
      in_rdy = (state_q != ST_PUSH);
      wr_en  = (state_q == ST_PUSH) && !bus.cmd_fifo_full;
   end

   assign bus.in_ready       = in_rdy;
   assign bus.cmd_fifo_wr_en = wr_en;
   assign bus.cmd_fifo_din   = din_q;
   assign err_resync         = err_resync_q;
   assign err_timeout        = err_timeout_q;
   assign cmd_count          = cnt_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// Directed bench for cmd_assembler with a short timeout and a 4-bit counter
// so that timeout and counter wrap are reachable in a few hundred cycles.
module tb_cmd_assembler;
   import cmd_assembler_pkg::*;

   localparam int TO = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clear_err = 1'b0;
   logic          err_resync;
   logic          err_timeout;
   logic [CW-1:0] cmd_count;

   cmd_assembler_if bus ();

   cmd_assembler #(
      .TIMEOUT_CYCLES(TO),
      .CNT_W         (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .clear_err  (clear_err),
      .err_resync (err_resync),
      .err_timeout(err_timeout),
      .cmd_count  (cmd_count)
   );

   always #5 clk = ~clk;

   int          n_vec  = 0;
   int          n_miss = 0;
   int          wr_cnt = 0;
   int          bad_wr = 0;
   logic [79:0] last_din = '0;

   // FIFO model: records every write the DUT makes.
   always @(posedge clk) begin
      if (rst && bus.cmd_fifo_wr_en) begin
         wr_cnt   <= wr_cnt + 1;
         last_din <= bus.cmd_fifo_din;
         if (bus.cmd_fifo_full) bad_wr <= bad_wr + 1;
      end
   end

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic sof);
      bus.in_data  = d;
      bus.in_sof   = sof;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic send_cmd(input logic [15:0] addr, input logic [31:0] data, input logic [31:0] tim);
      send(addr, 1'b1);
      send(data[15:0], 1'b0);
      send(data[31:16], 1'b0);
      send(tim[15:0], 1'b0);
      send(tim[31:16], 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int seen_wr;
      int seen_rdy;
      bus.in_data       = '0;
      bus.in_valid      = 1'b0;
      bus.in_sof        = 1'b0;
      bus.cmd_fifo_full = 1'b0;

      // Reset state
      repeat (3) tick();
      rst = 1'b1;
      chk("rst_in_ready",  bus.in_ready, 1);
      chk("rst_wr_en",     bus.cmd_fifo_wr_en, 0);
      chk("rst_din",       bus.cmd_fifo_din, 0);
      chk("rst_err_rsync", err_resync, 0);
      chk("rst_err_tmo",   err_timeout, 0);
      chk("rst_count",     cmd_count, 0);

      // Nominal back-to-back command
      send_cmd(16'h0010, 32'h1234_5678, 32'h0000_0064);
      chk("nom_wr_en",    bus.cmd_fifo_wr_en, 1);
      chk("nom_din",      bus.cmd_fifo_din, 80'h00000064_12345678_0010);
      chk("nom_in_ready", bus.in_ready, 0);
      tick();
      chk("nom_count",    cmd_count, 1);
      chk("nom_writes",   wr_cnt, 1);
      chk("nom_rdy_back", bus.in_ready, 1);

      // FIFO full for 20 cycles while holding a command
      bus.cmd_fifo_full = 1'b1;
      send_cmd(16'hA5A5, 32'hDEAD_BEEF, 32'h0000_0000);
      seen_wr  = 0;
      seen_rdy = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.cmd_fifo_wr_en) seen_wr++;
         if (bus.in_ready) seen_rdy++;
         tick();
      end
      chk("bp_wr_en_cycles", seen_wr, 0);
      chk("bp_ready_cycles", seen_rdy, 0);
      chk("bp_din_held",     bus.cmd_fifo_din, 80'h00000000_DEADBEEF_A5A5);
      chk("bp_no_write",     wr_cnt, 1);
      bus.cmd_fifo_full = 1'b0;
      #1;
      chk("bp_wr_on_drop",   bus.cmd_fifo_wr_en, 1);
      tick();
      chk("bp_count",        cmd_count, 2);
      chk("bp_written_din",  last_din, 80'h00000000_DEADBEEF_A5A5);

      // Resync: partial command interrupted by a new sof
      send(16'h1111, 1'b1);
      send(16'h2222, 1'b0);
      send(16'h3333, 1'b0);
      send(16'h4444, 1'b0);
      send_cmd(16'hFFFF, 32'hAAAA_BBBB, 32'h0000_0001);
      chk("rs_din",     bus.cmd_fifo_din, 80'h00000001_AAAABBBB_FFFF);
      chk("rs_err",     err_resync, 1);
      chk("rs_no_tmo",  err_timeout, 0);
      tick();
      chk("rs_writes",  wr_cnt, 3);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("rs_cleared", err_resync, 0);

      // Timeout after 8 idle cycles on a 2-word partial
      send(16'h0101, 1'b1);
      send(16'h0202, 1'b0);
      repeat (TO - 1) tick();
      chk("tmo_not_yet", err_timeout, 0);
      tick();
      chk("tmo_set",     err_timeout, 1);
      chk("tmo_writes",  wr_cnt, 3);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("tmo_cleared", err_timeout, 0);

      // Orphan word in IDLE, then a good command
      send(16'h0303, 1'b0);
      chk("orph_err",    err_resync, 1);
      send_cmd(16'h0042, 32'h0000_0001, 32'h0000_0000);
      chk("orph_din",    bus.cmd_fifo_din, 80'h00000000_00000001_0042);
      tick();
      chk("orph_writes", wr_cnt, 4);

      // sof arriving on the cycle the timeout would expire
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      send(16'h0101, 1'b1);
      send(16'h0202, 1'b0);
      repeat (TO - 1) tick();
      send_cmd(16'h7777, 32'h0000_0000, 32'h0000_0000);
      chk("col_resync", err_resync, 1);
      chk("col_no_tmo", err_timeout, 0);
      chk("col_din",    bus.cmd_fifo_din, 80'h00000000_00000000_7777);
      tick();
      chk("col_count",  cmd_count, 5);

      // Counter wrap (4-bit counter: 0xF -> 0x0)
      for (int i = 0; i < 10; i++) begin
         send_cmd(16'(i), 32'(i * 3), 32'(i));
         tick();
      end
      chk("wrap_max",    cmd_count, 4'hF);
      send_cmd(16'h00AA, 32'h0, 32'h0);
      tick();
      chk("wrap_zero",   cmd_count, 0);
      chk("wrap_writes", wr_cnt, 16);

      // Reset in the middle of COLLECT
      send(16'h0009, 1'b0);
      send(16'h0001, 1'b1);
      send(16'h0002, 1'b0);
      send(16'h0003, 1'b0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rc_err",      err_resync, 0);
      chk("rc_count",    cmd_count, 0);
      chk("rc_din",      bus.cmd_fifo_din, 0);
      chk("rc_ready",    bus.in_ready, 1);

      // Reset while a command waits in PUSH
      bus.cmd_fifo_full = 1'b1;
      send_cmd(16'h5555, 32'h6666_7777, 32'h8888_9999);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      bus.cmd_fifo_full = 1'b0;
      #1;
      chk("rp_wr_en",    bus.cmd_fifo_wr_en, 0);
      tick();
      chk("rp_writes",   wr_cnt, 16);
      chk("rp_count",    cmd_count, 0);

      // Clean command after reset, large time value passes unaltered
      send_cmd(16'hBEEF, 32'h0BAD_F00D, 32'h1234_5678);
      chk("post_din",    bus.cmd_fifo_din, 80'h12345678_0BADF00D_BEEF);
      tick();
      chk("post_count",  cmd_count, 1);
      chk("never_full_wr", bad_wr, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/cmd_assembler.md
CMD_ASSEMBLER -- requirements
Module: cmd_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning idle cycles allowed between words of one partial command before it is dropped.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the accepted-command counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous, active-low reset sampled on clk.
REQ-005 SHALL have port in_data, input, 16, the host bus word.
REQ-006 SHALL have port in_valid, input, 1, qualifying in_data.
REQ-007 SHALL have port in_sof, input, 1, marking in_data as word 0 of a command.
REQ-008 SHALL have port in_ready, output, 1; a word transfers on in_valid & in_ready.
REQ-009 SHALL have port cmd_fifo_din, output, 80, the assembled command {time[31:0], data[31:0], addr[15:0]}.
REQ-010 SHALL have port cmd_fifo_wr_en, output, 1, the FIFO write strobe.
REQ-011 SHALL have port cmd_fifo_full, input, 1, the FIFO full flag.
REQ-012 SHALL have port clear_err, input, 1, clearing sticky error flags.
REQ-013 SHALL have port err_resync, output, 1, a sticky framing-error flag.
REQ-014 SHALL have port err_timeout, output, 1, a sticky partial-command timeout flag.
REQ-015 SHALL have port cmd_count, output, CNT_W, the count of commands written to the FIFO.

Function
REQ-016 SHALL map words: w0 to bits 15:0 (addr), w1 to 31:16 (data lo), w2 to 47:32 (data hi), w3 to 63:48 (time lo), w4 to 79:64 (time hi).
REQ-017 SHALL implement states IDLE, COLLECT, PUSH.
REQ-018 IDLE: in_ready=1; a transfer with in_sof=1 stores w0, sets word index to 1 and goes to COLLECT.
REQ-019 IDLE: a transfer with in_sof=0 is discarded and sets err_resync.
REQ-020 COLLECT: in_ready=1; a transfer with in_sof=0 stores the word at the current index and increments it.
REQ-021 COLLECT: on the transfer of w4, the state goes to PUSH.
REQ-022 COLLECT: a transfer with in_sof=1 drops the partial command, stores the word as the new w0, sets index to 1 and sets err_resync.
REQ-023 COLLECT: an idle counter resets on every transfer; after TIMEOUT_CYCLES consecutive cycles without a transfer, the partial command is dropped, the state goes to IDLE and err_timeout is set.
REQ-024 If an sof transfer and timeout expiry fall on the same cycle, the sof handling SHALL win and only err_resync is set.
REQ-025 PUSH: in_ready=0; cmd_fifo_wr_en = !cmd_fifo_full, held stable with cmd_fifo_din until written.
REQ-026 PUSH: cmd_fifo_wr_en SHALL never be asserted while cmd_fifo_full=1.
REQ-027 PUSH: on the write cycle, cmd_count increments (wrapping at 2^CNT_W) and the state returns to IDLE.
REQ-028 PUSH: no timeout applies in PUSH.
REQ-029 Latency: w4 accepted in cycle N gives cmd_fifo_wr_en=1 in cycle N+1 when the FIFO is not full.
REQ-030 Throughput: max one command per 6 cycles.
REQ-031 cmd_fifo_din SHALL be registered, with unused upper bits of a partial command don't-care until PUSH.
REQ-032 clear_err clears both error flags; a same-cycle set SHALL win over clear.
REQ-033 All time/data values SHALL pass unaltered; time=0 is legal (immediate command).

Reset
REQ-034 rst=0 at a clk edge SHALL force state IDLE, index 0, idle counter 0, cmd_fifo_din 0, cmd_fifo_wr_en 0, in_ready 1 (after release), err flags 0 and cmd_count 0.
REQ-035 Reset mid-COLLECT or mid-PUSH SHALL discard the command with no FIFO write and no error flag.

Structure
REQ-036 A shared package SHALL hold the state encoding and the field bit positions (TIME_H/L=79/48, DATA_H/L=47/16, ADDR_H/L=15/0), also used by the scheduler.
REQ-037 Timeout counting SHALL live in one sub-module, idle_timer (load, count, expire output).
REQ-038 The block SHALL contain no other sub-modules.

Verification
REQ-039 Nominal: sof+0x0010, 0x5678, 0x1234, 0x0064, 0x0000 back-to-back -> one write, din=0x00000064_12345678_0010, 1 cycle after w4; cmd_count=1.
REQ-040 Full backpressure: cmd_fifo_full=1 for 20 cycles at PUSH -> wr_en=0, in_ready=0; write occurs in the cycle full drops; din unchanged.
REQ-041 Resync: sof+3 words then sof+0xFFFF and 4 words -> single write with addr=0xFFFF; err_resync=1.
REQ-042 Timeout: TIMEOUT_CYCLES=8, 2 words then 8 idle cycles -> IDLE, no write, err_timeout=1; clear_err -> 0.
REQ-043 Wrap/reset: 2^16 commands -> cmd_count wraps 0xFFFF->0x0000; rst=0 after w2 -> no write, counters 0.
REQ-044 Orphan word: in_sof=0 word in IDLE -> discarded, err_resync=1, next valid command written correctly.
